// File: rtl/serializer_pkg.sv
// Shared types and helpers for the MSB-first serializer.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // A zero bit-count encodes a full-width word.
    function automatic int unsigned len_decode(input int unsigned mod, input int unsigned width);
        return (mod == 0) ? width : mod;
    endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB-first, variable length, registered outputs.
// Define SERIALIZER_PARITY_EN to append one even-parity bit after each word.
module serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MIN_LEN = 3
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic [$clog2(DATA_W)-1:0] data_mod_i,
    input  logic                      data_val_i,
    output logic                      ser_data_o,
    output logic                      ser_data_val_o,
    output logic                      busy_o
);

    localparam int unsigned ModW = $clog2(DATA_W);
    localparam int unsigned CntW = ModW + 1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ser_q, ser_d;
    logic                val_q, val_d;
    logic                busy_q, busy_d;
    int unsigned         len_full;
`ifdef SERIALIZER_PARITY_EN
    logic                par_q, par_d;
`endif

    assign len_full = len_decode(32'(data_mod_i), DATA_W);

    // cnt_q counts the bits still owed, including the one currently on ser_data_o.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ser_d   = 1'b0;
        val_d   = 1'b0;
        busy_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_val_i && (len_full >= MIN_LEN)) begin
                    state_d = SHIFT;
                    shift_d = data_i << 1;
                    cnt_d   = CntW'(len_full);
                    ser_d   = data_i[DATA_W-1];
                    val_d   = 1'b1;
                    busy_d  = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    par_d   = data_i[DATA_W-1];
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == CntW'(1)) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d = PARITY;
                    ser_d   = par_q;
                    val_d   = 1'b1;
                    busy_d  = 1'b1;
`else
                    state_d = IDLE;
`endif
                end else begin
                    ser_d   = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - CntW'(1);
                    val_d   = 1'b1;
                    busy_d  = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    par_d   = par_q ^ shift_q[DATA_W-1];
`endif
                end
            end
            PARITY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ser_data_o     = ser_q;
    assign ser_data_val_o = val_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer; expectations follow SERIALIZER_PARITY_EN.
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    serializer #(
        .DATA_W  (16),
        .MIN_LEN (3)
    ) u_dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] m);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        data_i     = 16'h0F0F;
        data_mod_i = 4'd7;
    endtask

    task automatic collect(output int n, output logic [31:0] w, output int nb,
                           output int gap_bad, output int busy_bad);
        n = 0; w = '0; nb = 0; gap_bad = 0; busy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (ser_data_val_o === 1'b1) begin
                w = {w[30:0], ser_data_o};
                n++;
            end else if (n > 0) begin
                break;
            end
            if (ser_data_val_o !== 1'b1 && ser_data_o !== 1'b0) gap_bad++;
            if (busy_o !== ser_data_val_o) busy_bad++;
            if (busy_o === 1'b1) nb++;
            tick();
        end
    endtask

    task automatic check_stream(input string tag, input int len, input logic [31:0] bits,
                                input bit p);
        int          n, nb, gb, bb;
        logic [31:0] w;
        int          en;
        logic [31:0] ew;
        collect(n, w, nb, gb, bb);
        en = (len == 0) ? 0 : len + int'(PAR);
        ew = (len == 0) ? 32'h0 : (PAR ? ((bits << 1) | 32'(p)) : bits);
        check({tag, "_nbits"}, 32'(n), 32'(en));
        check({tag, "_word"}, w, ew);
        check({tag, "_busy_cycles"}, 32'(nb), 32'(en));
        check({tag, "_idle_bit"}, 32'(gb), 32'h0);
        check({tag, "_busy_eq_val"}, 32'(bb), 32'h0);
    endtask

    initial begin
        logic [9:0] val_pat;
        logic [9:0] ser_pat;

        srst_i     = 1'b1;
        data_i     = 16'h0;
        data_mod_i = 4'd0;
        data_val_i = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_cyc%0d", i), {29'h0, ser_data_o, ser_data_val_o, busy_o}, 32'h0);
        end
        srst_i = 1'b0;
        tick();
        check("reset_after", {29'h0, ser_data_o, ser_data_val_o, busy_o}, 32'h0);

        // A5C3 has eight ones, so even parity is 0.
        send(16'hA5C3, 4'd0);
        check_stream("full", 16, 32'hA5C3, 1'b0);

        send(16'hE000, 4'd3);
        check_stream("len3", 3, 32'h7, 1'b1);

        send(16'hFFFF, 4'd2);
        check_stream("len2", 0, 32'h0, 1'b0);
        send(16'hFFFF, 4'd1);
        check_stream("len1", 0, 32'h0, 1'b0);

        // Request held high: words separated by exactly one idle cycle.
        data_i     = 16'hFFFF;
        data_mod_i = 4'd4;
        data_val_i = 1'b1;
        tick();
        val_pat = '0;
        ser_pat = '0;
        for (int i = 0; i < 10; i++) begin
            val_pat = {val_pat[8:0], ser_data_val_o};
            ser_pat = {ser_pat[8:0], ser_data_o};
            if (i < 9) tick();
        end
        data_val_i = 1'b0;
        check("b2b_valid", 32'(val_pat), PAR ? 32'h3EF : 32'h3DE);
        check("b2b_data", 32'(ser_pat), PAR ? 32'h3CF : 32'h3DE);
        repeat (8) tick();
        check("b2b_drained", {29'h0, ser_data_o, ser_data_val_o, busy_o}, 32'h0);

        // Abort while bit 7 is on the line, with a request presented alongside reset.
        send(16'hA5C3, 4'd0);
        repeat (7) tick();
        check("abort_bit7", {30'h0, ser_data_o, ser_data_val_o}, 32'h3);
        srst_i     = 1'b1;
        data_i     = 16'h1234;
        data_mod_i = 4'd0;
        data_val_i = 1'b1;
        tick();
        check("abort_outputs", {29'h0, ser_data_o, ser_data_val_o, busy_o}, 32'h0);
        srst_i = 1'b0;
        tick();
        data_val_i = 1'b0;
        // 1234 has five ones, so even parity is 1.
        check_stream("after_abort", 16, 32'h1234, 1'b1);

        send(16'hB000, 4'd4);
        check_stream("par_b", 4, 32'hB, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
